// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scan controller: drives one shared BCD decoder across DIGITS
// common-anode positions with leading-zero blanking, decimal point and tear-free updates.
module disp_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  input  logic                  lzb_en,
  input  logic                  dp_en,
  input  logic [IW-1:0]         dp_pos,
  output logic [3:0]            code_out,
  output logic [DIGITS-1:0]     dig_n,
  output logic                  dp_n,
  output logic                  frame_done,
  output logic                  pend_full
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0]       div_cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] act;
  logic [4*DIGITS-1:0] pend;
  logic                tick;
  logic                wrap;

  logic [3:0]          d;
  logic                upper_zero;
  logic                lead_zero;
  logic                blank;
  logic [3:0]          code_next;
  logic [DIGITS-1:0]   dig_next;
  logic                dp_next;

  assign tick = (div_cnt == DW'(DIV - 1));
  assign wrap = tick && (idx == IW'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (tick) begin
        div_cnt <= '0;
        if (idx == IW'(DIGITS - 1))
          idx <= '0;
        else
          idx <= idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // act only moves at a frame wrap so a scan never mixes digits of two values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act       <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
    end else if (load && wrap) begin
      act       <= bcd_in;
      pend      <= bcd_in;
      pend_full <= 1'b0;
    end else if (load) begin
      pend      <= bcd_in;
      pend_full <= 1'b1;
    end else if (wrap && pend_full) begin
      act       <= pend;
      pend_full <= 1'b0;
    end
  end

  // lead_zero: every nibble from the top down to the current index is zero
  always_comb begin
    d          = 4'd0;
    upper_zero = 1'b1;
    lead_zero  = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (act[4*k +: 4] == 4'd0);
      if (IW'(k) == idx) begin
        d         = act[4*k +: 4];
        lead_zero = upper_zero;
      end
    end
    blank = (d > 4'd9) || (lzb_en && (idx != '0) && lead_zero);

    dig_next = '1;
    if (!blank) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (IW'(k) == idx)
          dig_next[k] = 1'b0;
      end
    end
    code_next = blank ? 4'd0 : d;
    dp_next   = !(dp_en && (dp_pos == idx) && !blank);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_out <= 4'd0;
      dig_n    <= '1;
      dp_n     <= 1'b1;
    end else begin
      code_out <= code_next;
      dig_n    <= dig_next;
      dp_n     <= dp_next;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl (DIV=4, DIGITS=4): stimulus queues hand-computed
// per-slot expectations, a monitor pops one mid-slot and checks frame_done every cycle.
module tb_disp_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] bcd_in;
  logic        load;
  logic        lzb_en;
  logic        dp_en;
  logic [1:0]  dp_pos;
  logic [3:0]  code_out;
  logic [3:0]  dig_n;
  logic        dp_n;
  logic        frame_done;
  logic        pend_full;

  int          cyc;
  int          errors = 0;
  int          checks = 0;
  int          slot_no = 0;
  logic [9:0]  exp_q[$];
  logic [9:0]  mon_e;
  logic        fd_exp;

  disp_scan_ctrl #(.DIGITS(4), .DIV(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bcd_in(bcd_in),
    .load(load),
    .lzb_en(lzb_en),
    .dp_en(dp_en),
    .dp_pos(dp_pos),
    .code_out(code_out),
    .dig_n(dig_n),
    .dp_n(dp_n),
    .frame_done(frame_done),
    .pend_full(pend_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cyc = number of active edges since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic expSlot(input logic [3:0] dg, input logic [3:0] cd, input logic dp, input logic pf);
    exp_q.push_back({dg, cd, dp, pf});
  endtask

  task automatic waitCyc(input int target);
    int guard;
    guard = 0;
    while (cyc != target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != target) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitCyc: cyc %0d expected %0d", cyc, target);
    end
  endtask

  task automatic applyStimulus(input int edge_cyc, input logic [15:0] value);
    waitCyc(edge_cyc - 1);
    bcd_in = value;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic zeroFrame();
    expSlot(4'b1110, 4'd0, 1'b1, 1'b0);
    expSlot(4'b1101, 4'd0, 1'b1, 1'b0);
    expSlot(4'b1011, 4'd0, 1'b1, 1'b0);
    expSlot(4'b0111, 4'd0, 1'b1, 1'b0);
  endtask

  // Monitor: reset entries are taken while rst_n is low, scan entries mid-slot
  initial begin
    forever begin
      @(negedge clk);
      fd_exp = rst_n && (cyc != 0) && (cyc % 16 == 0);
      checkOutput($sformatf("frame_done cyc%0d", cyc), {3'b0, frame_done}, {3'b0, fd_exp});
      if (exp_q.size() > 0 && (!rst_n || (cyc % 4 == 2))) begin
        mon_e = exp_q.pop_front();
        checkOutput($sformatf("slot%0d dig_n", slot_no), dig_n, mon_e[9:6]);
        checkOutput($sformatf("slot%0d code_out", slot_no), code_out, mon_e[5:2]);
        checkOutput($sformatf("slot%0d dp_n", slot_no), {3'b0, dp_n}, {3'b0, mon_e[1]});
        checkOutput($sformatf("slot%0d pend_full", slot_no), {3'b0, pend_full}, {3'b0, mon_e[0]});
        slot_no++;
      end
    end
  end

  initial begin
    rst_n  = 1'b1;
    bcd_in = 16'h0;
    load   = 1'b0;
    lzb_en = 1'b0;
    dp_en  = 1'b0;
    dp_pos = 2'd0;
    expSlot(4'b1111, 4'd0, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // idle frame, then a mid-frame double load where the last value wins
    zeroFrame();
    waitCyc(16);
    expSlot(4'b1110, 4'd0, 1'b1, 1'b0);
    expSlot(4'b1101, 4'd0, 1'b1, 1'b1);
    expSlot(4'b1011, 4'd0, 1'b1, 1'b1);
    expSlot(4'b0111, 4'd0, 1'b1, 1'b1);
    applyStimulus(19, 16'h5555);
    applyStimulus(23, 16'h1234);

    waitCyc(32);
    expSlot(4'b1110, 4'd4, 1'b1, 1'b0);
    expSlot(4'b1101, 4'd3, 1'b1, 1'b0);
    expSlot(4'b1011, 4'd2, 1'b1, 1'b1);
    expSlot(4'b0111, 4'd1, 1'b1, 1'b1);
    applyStimulus(40, 16'h0050);

    waitCyc(48);
    lzb_en = 1'b1;
    expSlot(4'b1110, 4'd0, 1'b1, 1'b0);
    expSlot(4'b1101, 4'd5, 1'b1, 1'b0);
    expSlot(4'b1111, 4'd0, 1'b1, 1'b1);
    expSlot(4'b1111, 4'd0, 1'b1, 1'b1);
    applyStimulus(56, 16'h0000);

    waitCyc(64);
    expSlot(4'b1110, 4'd0, 1'b1, 1'b0);
    expSlot(4'b1111, 4'd0, 1'b1, 1'b0);
    expSlot(4'b1111, 4'd0, 1'b1, 1'b1);
    expSlot(4'b1111, 4'd0, 1'b1, 1'b1);
    applyStimulus(72, 16'h12A4);

    waitCyc(80);
    expSlot(4'b1110, 4'd4, 1'b1, 1'b0);
    expSlot(4'b1111, 4'd0, 1'b1, 1'b0);
    expSlot(4'b1011, 4'd2, 1'b1, 1'b1);
    expSlot(4'b0111, 4'd1, 1'b1, 1'b1);
    applyStimulus(88, 16'h0505);

    waitCyc(96);
    dp_en  = 1'b1;
    dp_pos = 2'd2;
    expSlot(4'b1110, 4'd5, 1'b1, 1'b0);
    expSlot(4'b1101, 4'd0, 1'b1, 1'b0);
    expSlot(4'b1011, 4'd5, 1'b0, 1'b1);
    expSlot(4'b1111, 4'd0, 1'b1, 1'b1);
    applyStimulus(104, 16'h0005);

    // load lands exactly on the wrap edge (cyc 128)
    waitCyc(112);
    expSlot(4'b1110, 4'd5, 1'b1, 1'b0);
    expSlot(4'b1111, 4'd0, 1'b1, 1'b0);
    expSlot(4'b1111, 4'd0, 1'b1, 1'b0);
    expSlot(4'b1111, 4'd0, 1'b1, 1'b0);
    applyStimulus(128, 16'h9876);

    waitCyc(128);
    lzb_en = 1'b0;
    dp_en  = 1'b0;
    expSlot(4'b1110, 4'd6, 1'b1, 1'b0);
    expSlot(4'b1101, 4'd7, 1'b1, 1'b0);
    expSlot(4'b1011, 4'd8, 1'b1, 1'b0);
    expSlot(4'b0111, 4'd9, 1'b1, 1'b0);

    // asynchronous reset mid-slot with a value pending
    waitCyc(144);
    expSlot(4'b1110, 4'd6, 1'b1, 1'b0);
    expSlot(4'b1101, 4'd7, 1'b1, 1'b1);
    applyStimulus(150, 16'h1111);
    @(posedge clk);
    #1;
    expSlot(4'b1111, 4'd0, 1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    zeroFrame();
    zeroFrame();
    waitCyc(34);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Time-multiplexes one shared BCD-to-7-segment decoder across DIGITS common-anode digit positions of the duty-cycle meter display.
- Holds the value to show and scans digits at a divided rate.
- Applies leading-zero blanking and decimal-point placement.
- Double-buffers new values so an update never tears mid-frame.
- Sits between the measurement/BCD-conversion logic and the decoder plus digit drivers.

Parameters:
- DIGITS, 4, number of multiplexed digit positions (2..8); index 0 = least significant.
- DIV, 50000, clk cycles per digit slot (>=2); 50 MHz gives 1 ms per digit.
- IW, $clog2(DIGITS), digit index width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bcd_in  in  4*DIGITS  packed BCD value; nibble i = digit i.
- load  in  1  one-cycle strobe; captures bcd_in into the pending buffer.
- lzb_en  in  1  leading-zero blanking enable.
- dp_en  in  1  decimal point enable.
- dp_pos  in  IW  digit index that carries the decimal point.
- code_out  out  4  BCD nibble to the shared decoder input.
- dig_n  out  DIGITS  digit enables, active-low, at most one low.
- dp_n  out  1  decimal point segment, active-low.
- frame_done  out  1  one-cycle pulse at the end of each full scan.
- pend_full  out  1  pending buffer holds a value not yet displayed.

Behaviour:
- Reset state, asynchronous while rst_n=0:
  - div_cnt=0, idx=0, act=0, pend=0, pend_full=0.
  - code_out=0, dig_n=all ones, dp_n=1, frame_done=0.
- Prescaler:
  - div_cnt counts 0..DIV-1 and wraps.
  - tick=1 in the cycle where div_cnt==DIV-1.
- Digit index:
  - On tick, idx advances by 1 and wraps from DIGITS-1 to 0.
  - wrap = tick && idx==DIGITS-1.
- frame_done is registered. It is 1 for exactly the one cycle after a wrap cycle, otherwise 0.
- Buffering:
  - load=1: pend<=bcd_in and pend_full<=1. A later load before a wrap overwrites pend (last value wins).
  - wrap with pend_full=1: act<=pend and pend_full<=0.
  - load and wrap in the same cycle: act<=bcd_in directly, pend<=bcd_in, pend_full<=0.
  - act never changes at any other time.
- Outputs are registered. Every cycle they reflect the current idx and act, so they change one cycle after idx or act changes. Within a slot, outputs are stable for DIV-1 cycles.
  - d = act nibble idx.
  - Blanking:
    - blank=1 if d>9.
    - blank=1 if lzb_en=1 and idx!=0 and every nibble from DIGITS-1 down to idx is 0.
    - Digit 0 is never blanked for zero.
  - blank=0: code_out=d and dig_n bit idx=0, others 1.
  - blank=1: code_out=0 and dig_n=all ones.
  - dp_n=0 iff dp_en=1, dp_pos==idx and blank=0.
- Output gap: one cycle at each slot boundary where the old digit stays driven. This is accepted (no ghosting guard).
- Reset mid-frame: everything returns to the reset state immediately. A pending value is discarded. The scan restarts at idx=0 after release.
- Inputs are synchronous to clk; no CDC inside this block.

Test Plan (DIV=4, DIGITS=4 unless stated):
- Reset then idle, no load:
  - act=0, lzb_en=0: dig_n cycles 1110,1101,1011,0111, each held 4 cycles.
  - code_out=0 throughout.
  - frame_done pulses every 16 cycles.
- Load 0x1234 mid-frame:
  - Displayed digits stay 0 until the next wrap; pend_full=1 until then.
  - After the wrap: code_out 4,3,2,1 on idx 0..3.
  - pend_full returns to 0 at the wrap.
- lzb_en=1, act=0x0050:
  - idx3 and idx2 give dig_n=1111.
  - idx1 gives code 5; idx0 gives code 0 with dig_n=1110.
  - act=0x0000 shows only digit 0.
- Illegal nibble, act=0x12A4: slot idx1 blanked (dig_n=1111, code_out=0); the other digits display normally.
- Decimal point:
  - dp_en=1, dp_pos=2, act=0x0505, lzb_en=1: dp_n=0 only in the idx2 slot (digit 5 shown).
  - With act=0x0005, idx2 is blanked, so dp_n stays 1.
- Corner timing cases:
  - load asserted exactly in a wrap cycle with 0x9876: next frame shows 6,7,8,9 and pend_full=0.
  - rst_n pulsed low mid-slot with pend_full=1: outputs go to reset values asynchronously; after release the display shows 0 and pend_full=0.
